ntt_bram_stream: RTL
====================

Name: ntt_bram_stream

Overview:
- Streaming load/unload front-end for the 4096x18 NTT coefficient BRAM (1-cycle registered-address read).
- Load phase accepts N coefficients over a valid/ready input and writes them to the BRAM, optionally at bit-reversed addresses, ready for in-place NTT passes.
- Unload phase reads the BRAM in natural order and streams the words out over a valid/ready output. It absorbs the read latency with a 2-entry output buffer, so backpressure never loses data.

Parameters:
- DW, 18, coefficient / BRAM data width
- AW, 12, BRAM address width; N = 2^AW words per transfer
- BITREV, 1, 1: load address = bit-reverse(count); 0: natural order

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start_load  in  1  one-cycle request to begin a load (honoured in IDLE only)
- start_unload  in  1  one-cycle request to begin an unload (honoured in IDLE only)
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid & in_ready
- in_data  in  DW  input coefficient
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  DW  output coefficient (registered)
- busy  out  1  state != IDLE
- load_done  out  1  one-cycle pulse, load finished
- unload_done  out  1  one-cycle pulse, unload finished
- bram_wr_en  out  1  to BRAM wr_en
- bram_wr_addr  out  AW  to BRAM wr_addr
- bram_wr_din  out  DW  to BRAM wr_din
- bram_rd_addr  out  AW  to BRAM rd_addr
- bram_rd_dout  in  DW  from BRAM rd_dout, valid the cycle after bram_rd_addr is presented

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; counters 0; buffer empty.
  - in_ready, out_valid, busy, load_done, unload_done, bram_wr_en = 0.
  - out_data, bram_wr_addr, bram_rd_addr, bram_wr_din = 0.
  - Reset mid-transfer aborts it silently; no done pulse is generated.
- States:
  - IDLE: start_load -> LOAD; else start_unload -> UNLOAD_ISSUE. If both are asserted, load wins and start_unload is dropped.
  - start_* outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - Each handshake: bram_wr_en=1 combinationally in that cycle; bram_wr_din=in_data; bram_wr_addr = BITREV ? bitrev(wcnt) : wcnt; wcnt++.
  - On the handshake with wcnt=N-1: wcnt wraps to 0 and state -> IDLE; load_done pulses the next cycle (registered).
  - No handshake means no write, no count.
- UNLOAD_ISSUE:
  - Read issue condition: fill + inflight - pop < 2, where fill = buffer occupancy (0..2), inflight = read issued last cycle, pop = out_valid & out_ready.
  - On issue: bram_rd_addr=rcnt, rcnt++, inflight set next cycle.
  - Returning bram_rd_dout is pushed into the buffer the cycle after issue.
  - After issuing rcnt=N-1 -> UNLOAD_DRAIN.
  - Full throughput: 1 word/cycle when out_ready is held high. First out_valid occurs 2 cycles after the start_unload cycle (read issued, BRAM returns, buffer register).
- UNLOAD_DRAIN: no issues. When inflight=0 and the buffer empties (last pop), state -> IDLE and unload_done pulses the next cycle.
- Output buffer:
  - 2-entry FIFO; out_data = head register, out_valid = fill != 0.
  - Simultaneous push and pop keeps fill unchanged and preserves order.
  - The issue rule guarantees no overflow; a push into a full buffer is an assertion failure.
- Ordering: words exit in address order 0..N-1, exactly N per unload, with no duplicates or drops under any out_ready pattern.
- BRAM hazard: LOAD and UNLOAD are mutually exclusive, so there are no read/write collisions. Data written in LOAD is readable by any later unload.
- Address counters are AW bits wide and wrap naturally; no transfer ever exceeds N.

Decomposition:
- Shared package ntt_stream_pkg: state enum (IDLE, LOAD, UNLOAD_ISSUE, UNLOAD_DRAIN) and a bitrev(AW) function.
- One sub-module: ntt_skid2, a 2-entry valid/ready output buffer exposing a fill count.
- Everything else lives in the top level.

Test Plan:
- BITREV=1, AW=3, load 0..7 with in_valid held high -> writes at addresses 0,4,2,6,1,5,3,7 on 8 consecutive cycles; load_done pulses once, 1 cycle after the 8th write.
- After the above, unload with out_ready=1 -> out_data 0,4,2,6,1,5,3,7 on 8 consecutive cycles, first 2 cycles after start_unload; unload_done pulses once.
- Unload with out_ready toggling 1,0,0,1,... plus random stalls (AW=12, data=addr) -> exactly 4096 words in order 0..4095; the buffer never overflows.
- start_load and start_unload in the same cycle -> LOAD entered; start_unload during LOAD ignored; busy=1 throughout.
- Random in_valid gaps during load (AW=4, BITREV=0) -> write count is 16, addresses contiguous; no bram_wr_en without a handshake.
- rst asserted mid-unload after 5 words -> all outputs 0 immediately; no unload_done; a fresh unload restarts from address 0.

Source files
------------

// File: rtl/ntt_stream_pkg.sv
// Shared types and helpers for the NTT BRAM streaming front-end.
package ntt_stream_pkg;

  localparam int unsigned MAX_AW = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD_ISSUE,
    UNLOAD_DRAIN
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v,
                                               input int unsigned      w);
    logic [MAX_AW-1:0] r;
    r = {<<{v}};
    return r >> (MAX_AW - w);
  endfunction

endpackage

// File: rtl/ntt_bram_stream_if.sv
// Input and output valid/ready coefficient streams of the NTT BRAM front-end.
interface ntt_bram_stream_if #(
  parameter int DW = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ntt_skid2.sv
// Two-entry valid/ready output buffer; the head register drives the output directly.
module ntt_skid2 #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_fill
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_fill;
  logic          w_pop;

  assign o_valid = (r_fill != 2'd0);
  assign o_data  = r_head;
  assign o_fill  = r_fill;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_fill == 2'd0) r_head <= i_data;
          else                r_tail <= i_data;
          r_fill <= r_fill + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_fill <= r_fill - 2'd1;
        end
        2'b11: begin
          // Pop and push together: the incoming word lands behind whatever remains.
          if (r_fill == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !w_pop && r_fill == 2'd2));

endmodule

// File: rtl/ntt_bram_stream.sv
// Streaming load/unload front-end for the NTT coefficient BRAM (1-cycle read latency).
module ntt_bram_stream
  import ntt_stream_pkg::*;
#(
  parameter int DW     = 18,
  parameter int AW     = 12,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_load,
  input  logic                start_unload,
  ntt_bram_stream_if.slave    strm,
  output logic                busy,
  output logic                load_done,
  output logic                unload_done,
  output logic                bram_wr_en,
  output logic [AW-1:0]       bram_wr_addr,
  output logic [DW-1:0]       bram_wr_din,
  output logic [AW-1:0]       bram_rd_addr,
  input  logic [DW-1:0]       bram_rd_dout
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wcnt;
  logic [AW-1:0] r_rcnt;
  logic          r_inflight;
  logic          r_load_done;
  logic          r_unload_done;
  logic          w_wr_hs;
  logic          w_issue;
  logic          w_room;
  logic          w_pop;
  logic          w_load_fin;
  logic          w_unload_fin;
  logic [1:0]    w_fill;

  ntt_skid2 #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (bram_rd_dout),
    .i_ready (strm.out_ready),
    .o_valid (strm.out_valid),
    .o_data  (strm.out_data),
    .o_fill  (w_fill)
  );

  assign w_pop  = strm.out_valid & strm.out_ready;
  // Space left once this cycle's pop and the returning read are accounted for.
  assign w_room = ({1'b0, w_fill} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_hs      = 1'b0;
    w_issue      = 1'b0;
    w_load_fin   = 1'b0;
    w_unload_fin = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_load) begin
          w_state_nxt = LOAD;
        end else if (start_unload) begin
          // Address 0 goes out in the start cycle so the first word appears two cycles later.
          w_state_nxt = UNLOAD_ISSUE;
          w_issue     = 1'b1;
        end
      end
      LOAD: begin
        w_wr_hs = strm.in_valid;
        if (strm.in_valid && r_wcnt == '1) begin
          w_state_nxt = IDLE;
          w_load_fin  = 1'b1;
        end
      end
      UNLOAD_ISSUE: begin
        w_issue = w_room;
        if (w_room && r_rcnt == '1) w_state_nxt = UNLOAD_DRAIN;
      end
      UNLOAD_DRAIN: begin
        if (!r_inflight && (w_fill == 2'd0 || (w_fill == 2'd1 && w_pop))) begin
          w_state_nxt  = IDLE;
          w_unload_fin = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wcnt        <= '0;
      r_rcnt        <= '0;
      r_inflight    <= 1'b0;
      r_load_done   <= 1'b0;
      r_unload_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_inflight    <= w_issue;
      r_load_done   <= w_load_fin;
      r_unload_done <= w_unload_fin;
      if (w_wr_hs) r_wcnt <= r_wcnt + 1'b1;
      if (w_issue) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  assign strm.in_ready = (r_state == LOAD);
  assign busy          = (r_state != IDLE);
  assign load_done     = r_load_done;
  assign unload_done   = r_unload_done;
  assign bram_wr_en    = w_wr_hs;
  assign bram_wr_din   = w_wr_hs ? strm.in_data : '0;
  assign bram_wr_addr  = (BITREV != 0) ? AW'(bitrev(32'(r_wcnt), AW)) : r_wcnt;
  assign bram_rd_addr  = r_rcnt;

endmodule
